spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_half_period_timer.sv | 29 ++
 rtl/spi_master.sv | 150 +++++++++++++++
 tb/tb_spi_master.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// spi_pkg - shared state encoding, frame geometry and frame builder for spi_master (rev 1.0)
package spi_pkg;

  localparam int   FRAME_LEN = 16;
  localparam int   ADDR_W    = 7;
  localparam int   DATA_W    = 8;
  localparam logic RW_READ   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Read frames carry an all-zero data field.
  function automatic logic [FRAME_LEN-1:0] build_frame(
    input logic              rw,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] wdata
  );
    return {addr, rw, (rw == RW_READ) ? {DATA_W{1'b0}} : wdata};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_half_period_timer.sv
`default_nettype none
// spi_half_period_timer - emits a one-cycle tick every HALF_PERIOD clk cycles after load (rev 1.0)
module spi_half_period_timer #(
  parameter int HALF_PERIOD = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_tick
);

  localparam int CNT_W = $clog2(HALF_PERIOD + 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = (r_cnt == CNT_W'(HALF_PERIOD - 1)) && !i_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// spi_master - 16-bit mode-0 SPI master for a byte-wide memory slave (rev 1.0)
module spi_master
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 50,
  parameter int CS_GAP      = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ready,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
);

  localparam int GAP_W = $clog2(CS_GAP + 1);

  state_t                 r_state;
  logic                   r_ready;
  logic                   r_done;
  logic                   r_sclk;
  logic                   r_cs;
  logic                   r_mosi;
  logic [DATA_W-1:0]      r_rdata;
  logic [DATA_W-1:0]      r_rx;
  logic [FRAME_LEN-2:0]   r_tail;
  logic                   r_rw;
  logic [4:0]             r_bit_cnt;
  logic [GAP_W-1:0]       r_gap_cnt;

  logic [FRAME_LEN-1:0]   w_frame;
  logic                   w_load;
  logic                   w_tick;

  assign w_frame = build_frame(rw, addr, wdata);
  // The timer free-runs only while a frame is on the wire.
  assign w_load  = (r_state == ST_IDLE) || (r_state == ST_GAP);

  spi_half_period_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_load(w_load),
    .o_tick(w_tick)
  );

  assign ready = r_ready;
  assign done  = r_done;
  assign sclk  = r_sclk;
  assign cs    = r_cs;
  assign mosi  = r_mosi;
  assign rdata = r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_sclk    <= 1'b0;
      r_cs      <= 1'b1;
      r_mosi    <= 1'b0;
      r_rdata   <= '0;
      r_rx      <= '0;
      r_tail    <= '0;
      r_rw      <= 1'b0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_tail    <= w_frame[FRAME_LEN-2:0];
            r_mosi    <= w_frame[FRAME_LEN-1];
            r_rw      <= rw;
            r_cs      <= 1'b0;
            r_ready   <= 1'b0;
            r_bit_cnt <= '0;
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_tick) begin
            r_sclk    <= 1'b1;
            r_bit_cnt <= 5'd1;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            if (r_sclk) begin
              r_sclk <= 1'b0;
              r_mosi <= r_tail[FRAME_LEN-2];
              r_tail <= {r_tail[FRAME_LEN-3:0], 1'b0};
            end else begin
              r_sclk    <= 1'b1;
              r_bit_cnt <= r_bit_cnt + 5'd1;
              // Data phase: capture miso just ahead of rising edges 9..16.
              if ((r_rw == RW_READ) && (r_bit_cnt >= 5'(FRAME_LEN - DATA_W))) begin
                r_rx <= {r_rx[DATA_W-2:0], miso};
              end
              if (r_bit_cnt == 5'(FRAME_LEN - 1)) begin
                r_state <= ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            if (r_sclk) begin
              r_sclk <= 1'b0;
              r_mosi <= 1'b0;
            end else begin
              r_cs      <= 1'b1;
              r_done    <= 1'b1;
              r_gap_cnt <= '0;
              r_state   <= ST_GAP;
              if (r_rw == RW_READ) begin
                r_rdata <= r_rx;
              end
            end
          end
        end
        ST_GAP: begin
          // The IDLE cycle that accepts the next start is the last cs-high cycle.
          if (r_gap_cnt == GAP_W'(CS_GAP - 2)) begin
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// tb_spi_master - randomized scoreboard bench for spi_master against a memory-slave model (rev 1.0)
module tb_spi_master;

  localparam int HALF_PERIOD = 50;
  localparam int CS_GAP      = 100;
  localparam int WAIT_LIMIT  = 6000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       rw    = 1'b0;
  logic [6:0] addr  = '0;
  logic [7:0] wdata = '0;
  logic       ready, done, sclk, cs, mosi, miso;
  logic [7:0] rdata;

  always #5 clk = ~clk;

  spi_master #(
    .HALF_PERIOD(HALF_PERIOD),
    .CS_GAP     (CS_GAP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .ready(ready),
    .rw   (rw),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .done (done),
    .sclk (sclk),
    .cs   (cs),
    .mosi (mosi),
    .miso (miso)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents and the rdata value the master should hold.
  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rdata;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] ref_mem[128];
  logic [7:0] model_rdata = 8'h00;
  bit         tie_one     = 1'b0;

  task automatic model_push(input logic r, input logic [6:0] a, input logic [7:0] d);
    exp_t e;
    e.frame = {a, r, (r ? 8'h00 : d)};
    if (r) model_rdata = tie_one ? 8'hFF : ref_mem[a];
    else   ref_mem[a] = d;
    e.rdata = model_rdata;
    sb_q.push_back(e);
  endtask

  // Memory slave: shifts mosi on rising sclk, drives miso on falling sclk.
  int          s_cnt    = 0;
  logic [15:0] s_shift  = '0;
  logic [15:0] obs_frame = '0;
  logic        s_rd     = 1'b0;
  logic [7:0]  s_data   = '0;
  logic        s_miso   = 1'b0;
  logic [7:0]  smem[128];

  assign miso = tie_one ? 1'b1 : s_miso;

  always @(negedge cs) begin
    s_cnt  = 0;
    s_rd   = 1'b0;
    s_miso = 1'b0;
  end

  always @(posedge sclk) begin
    if (!cs) begin
      s_shift = {s_shift[14:0], mosi};
      s_cnt++;
      if (s_cnt == 8) begin
        s_rd   = s_shift[0];
        s_data = smem[s_shift[7:1]];
      end
      if (s_cnt == 16) begin
        obs_frame = s_shift;
        if (!s_rd) smem[s_shift[15:9]] = s_shift[7:0];
      end
    end
  end

  always @(negedge sclk) begin
    if (!cs && s_rd && s_cnt >= 8 && s_cnt < 16) s_miso = s_data[3'(15 - s_cnt)];
  end

  // Monitor: line timing, line rules and scoreboard pops on done.
  int   cyc = 0, hi_cnt = 0, last_hi_run = 0, nrise = 0, first_gap = 0;
  int   last_rise = 0, t_csfall = 0, spacing_bad = 0, viol = 0;
  bit   aborted = 1'b0;
  logic p_cs = 1'b1, p_sclk = 1'b0, p_ready = 1'b1, p_mosi = 1'b0, p_done = 1'b0;
  exp_t m_e;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) aborted = 1'b1;
    if (cs) hi_cnt++;
    if (p_cs && !cs) begin
      last_hi_run = hi_cnt;
      hi_cnt      = 0;
      nrise       = 0;
      spacing_bad = 0;
      aborted     = 1'b0;
      t_csfall    = cyc;
    end
    if (!p_sclk && sclk) begin
      if (nrise == 0) first_gap = cyc - t_csfall;
      else if (cyc - last_rise != 2 * HALF_PERIOD) spacing_bad++;
      last_rise = cyc;
      nrise++;
    end
    if (!p_cs && cs && !aborted) begin
      check("rise_count", nrise, 16);
      check("cs_fall_to_first_rise", first_gap, HALF_PERIOD);
      check("rise_spacing_errors", spacing_bad, 0);
      check("last_rise_to_cs_rise", cyc - last_rise, 2 * HALF_PERIOD);
    end
    if (!p_ready && ready && !aborted) check("cs_high_cycles_at_ready", hi_cnt, CS_GAP);
    if (cs && (sclk || mosi)) viol++;
    if (!cs && !p_cs && (mosi !== p_mosi) && !(p_sclk && !sclk)) viol++;
    if (done && p_done) viol++;
    if (done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'(done), 0);
      end else begin
        m_e = sb_q.pop_front();
        check("rdata_at_done", 32'(rdata), 32'(m_e.rdata));
        check("mosi_frame", 32'(obs_frame), 32'(m_e.frame));
        check("done_in_first_gap_cycle", hi_cnt, 1);
      end
    end
    p_cs    = cs;
    p_sclk  = sclk;
    p_ready = ready;
    p_mosi  = mosi;
    p_done  = done;
  end

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!ready && k < WAIT_LIMIT) begin
      @(negedge clk);
      k++;
    end
    check("wait_ready", 32'(ready), 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((sb_q.size() != 0 || !ready) && k < WAIT_LIMIT) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drained", sb_q.size(), 0);
  endtask

  task automatic wait_rises(input int n);
    int k = 0;
    while (s_cnt < n && k < WAIT_LIMIT) begin
      @(negedge clk);
      k++;
    end
    check("slave_rise_count", s_cnt, n);
  endtask

  task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d);
    wait_ready();
    rw    = r;
    addr  = a;
    wdata = d;
    start = 1'b1;
    model_push(r, a, d);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got no completion, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 8'(i * 29 + 3);
      smem[i]    = 8'(i * 29 + 3);
    end
    #1 rst_n = 1'b0;
    #2;
    check("reset_cs", 32'(cs), 1);
    check("reset_sclk", 32'(sclk), 0);
    check("reset_mosi", 32'(mosi), 0);
    check("reset_ready", 32'(ready), 1);
    check("reset_done", 32'(done), 0);
    check("reset_rdata", 32'(rdata), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed write then read-back of the same word.
    issue(1'b0, 7'h01, 8'h55);
    issue(1'b1, 7'h01, 8'h00);

    // start held high across two frames.
    wait_ready();
    rw = 1'b0; addr = 7'($urandom); wdata = 8'($urandom); start = 1'b1;
    model_push(rw, addr, wdata);
    @(posedge clk);
    #1;
    rw = 1'b1; addr = 7'($urandom); wdata = 8'($urandom);
    wait_ready();
    model_push(rw, addr, wdata);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    #1 check("b2b_cs_high_cycles", last_hi_run, CS_GAP);

    // start pulsed mid-frame must be ignored.
    issue(1'b0, 7'($urandom), 8'($urandom));
    wait_rises(3);
    rw = 1'b0; addr = 7'($urandom); wdata = 8'($urandom); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("ready_low_mid_frame", 32'(ready), 0);
    wait_idle();

    // Asynchronous reset after five rising edges of a read.
    issue(1'b1, 7'($urandom), 8'h00);
    wait_rises(5);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_cs", 32'(cs), 1);
    check("async_reset_sclk", 32'(sclk), 0);
    check("async_reset_mosi", 32'(mosi), 0);
    sb_q.delete();
    model_rdata = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(ready), 1);
    check("rdata_after_reset", 32'(rdata), 0);
    repeat (4 * HALF_PERIOD) @(negedge clk);

    // miso tied high: read of 0x7F, then a write must leave rdata alone.
    wait_idle();
    tie_one = 1'b1;
    issue(1'b1, 7'h7F, 8'h00);
    issue(1'b0, 7'($urandom), 8'hAA);
    wait_idle();
    check("rdata_kept_after_write", 32'(rdata), 32'hFF);
    tie_one = 1'b0;

    for (int i = 0; i < 12; i++) begin
      issue(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom));
    end
    wait_idle();
    check("line_rule_violations", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
